// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart_tx arbitration slice.
//   BYTE_W      : width of one transmitted byte
//   arb_state_e : arbiter state encoding (IDLE / SEND / WAIT_ACK / WAIT_DONE)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_rr_picker.sv
// ---------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin selector. It scans the requesters starting at
// ptr_i and wrapping around. It returns the first one that is both
// requesting and allowed by the eligibility mask.
// Ports:
//   req_i  [N_REQ-1:0] request vector
//   ptr_i  [IW-1:0]    index holding highest priority
//   mask_i [N_REQ-1:0] eligibility mask (1 = may win)
//   gnt_o  [N_REQ-1:0] one-hot winner, zero when nobody qualifies
//   idx_o  [IW-1:0]    binary index of the winner
//   any_o              a winner exists
// ---------------------------------------------------------------------------
module uart_rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0] gnt_s;
    logic [IW-1:0]    idx_s;
    logic             found_s;

    // Rotating priority scan: the first eligible requester at or after ptr_i wins
    always_comb begin
        int cand;
        gnt_s   = {N_REQ{1'b0}};
        idx_s   = {IW{1'b0}};
        found_s = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_i) + k;
            // ptr_i < N_REQ, so one subtraction is enough to wrap
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (!found_s && req_i[cand] && mask_i[cand]) begin
                found_s     = 1'b1;
                gnt_s[cand] = 1'b1;
                idx_s       = IW'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign gnt_o = gnt_s;
    assign idx_o = idx_s;
    assign any_o = found_s;

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx transmitter between N_REQ byte requesters. Arbitration
// is round-robin, and exactly one byte is in flight at a time.
// Build option: define UART_TX_ARBITER_LOCK_EN to hold the grant across a
// multi-byte packet, which is terminated by req_last. When the macro is
// undefined, req_last is ignored.
// Parameters:
//   N_REQ       number of requesters (2..8)
//   ACK_TIMEOUT cycles after tx_enable allowed for tx_busy to rise (>=2)
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid [N_REQ]    requester i has a byte pending
//   req_data  [8*N_REQ]  byte of requester i at [8i+7:8i]
//   req_last  [N_REQ]    byte closes its packet (lock build only)
//   req_ready [N_REQ]    one-cycle accept pulse
//   tx_busy              uart_tx busy
//   tx_enable            one-cycle start pulse to uart_tx
//   tx_data   [8]        byte for uart_tx
//   grant     [N_REQ]    one-hot current owner, zero when idle
//   tx_drop              one-cycle pulse: uart_tx never acknowledged, byte lost
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    tx_busy,
    output logic                    tx_enable,
    output logic [BYTE_W-1:0]       tx_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_drop
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              tx_enable_q, tx_enable_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              tx_drop_q, tx_drop_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              lock_s;
    logic [N_REQ-1:0]  elig_s;
    logic [N_REQ-1:0]  pick_gnt_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_any_s;
    logic              accept_s;
    logic [IW-1:0]     accept_idx_s;
    logic [N_REQ-1:0]  accept_oh_s;
    logic              drop_s;

    // While a packet is locked, only its owner may be picked
    assign elig_s = lock_s ? grant_q : {N_REQ{1'b1}};

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .mask_i (elig_s),
        .gnt_o  (pick_gnt_s),
        .idx_o  (pick_idx_s),
        .any_o  (pick_any_s)
    );

    // Next-state logic; a byte acceptance overrides the per-state defaults
    always_comb begin
        state_d      = state_q;
        tx_enable_d  = 1'b0;
        tx_data_d    = tx_data_q;
        req_ready_d  = {N_REQ{1'b0}};
        grant_d      = grant_q;
        tx_drop_d    = 1'b0;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        accept_s     = 1'b0;
        accept_idx_s = owner_q;
        accept_oh_s  = grant_q;
        drop_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A frame still leaving uart_tx (e.g. across a reset) blocks arbitration
                if (!tx_busy && pick_any_s) begin
                    accept_s     = 1'b1;
                    accept_idx_s = pick_idx_s;
                    accept_oh_s  = pick_gnt_s;
                end else begin
                    accept_s = 1'b0;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_ACK;
                cnt_d   = {CW{1'b0}};
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 2)) begin
                    // The SEND cycle plus ACK_TIMEOUT-1 wait cycles put the drop
                    // pulse exactly ACK_TIMEOUT cycles after tx_enable
                    state_d   = ST_IDLE;
                    tx_drop_d = 1'b1;
                    drop_s    = 1'b1;
                    grant_d   = {N_REQ{1'b0}};
                end else if (cnt_q != CW'(ACK_TIMEOUT)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (lock_s && req_valid[owner_q]) begin
                    // Back-to-back packet byte: skip IDLE to keep the gap at one cycle
                    accept_s     = 1'b1;
                    accept_idx_s = owner_q;
                    accept_oh_s  = grant_q;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = lock_s ? grant_q : {N_REQ{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {N_REQ{1'b0}};
            end
        endcase

        if (accept_s) begin
            state_d     = ST_SEND;
            tx_enable_d = 1'b1;
            req_ready_d = accept_oh_s;
            grant_d     = accept_oh_s;
            tx_data_d   = req_data[int'(accept_idx_s) * BYTE_W +: BYTE_W];
            owner_d     = accept_idx_s;
            ptr_d       = (accept_idx_s == IW'(N_REQ - 1)) ? {IW{1'b0}}
                                                           : accept_idx_s + IW'(1);
        end else begin
            owner_d = owner_d;
        end
    end

`ifdef UART_TX_ARBITER_LOCK_EN
    logic lock_q, lock_d;

    // Packet lock: opened by a non-last byte, closed by a last byte or a drop
    always_comb begin
        lock_d = lock_q;
        if (accept_s) begin
            lock_d = ~req_last[accept_idx_s];
        end else if (drop_s) begin
            lock_d = 1'b0;
        end else begin
            lock_d = lock_q;
        end
    end

    // Packet lock register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock_s = lock_q;
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;
    assign lock_s        = 1'b0;
`endif

    // Arbiter state, capture registers, pointer and timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_enable_q <= 1'b0;
            tx_data_q   <= {BYTE_W{1'b0}};
            req_ready_q <= {N_REQ{1'b0}};
            grant_q     <= {N_REQ{1'b0}};
            tx_drop_q   <= 1'b0;
            ptr_q       <= {IW{1'b0}};
            owner_q     <= {IW{1'b0}};
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            grant_q     <= grant_d;
            tx_drop_q   <= tx_drop_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign tx_enable = tx_enable_q;
    assign tx_data   = tx_data_q;
    assign req_ready = req_ready_q;
    assign grant     = grant_q;
    assign tx_drop   = tx_drop_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench for uart_tx_arbiter (N_REQ=4, ACK_TIMEOUT=8). Directed
// tests push the expected (requester, byte) sequence into a queue. A monitor
// pops one entry per tx_enable. A small uart_tx model raises tx_busy one
// cycle after tx_enable and holds it for 10 cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int BUSY_LEN = 10;
`ifdef UART_TX_ARBITER_LOCK_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            tx_busy;
    logic            tx_enable;
    logic [7:0]      tx_data;
    logic [NR-1:0]   grant;
    logic            tx_drop;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic [8:0]  rbuf[NR][16];
    int          rcnt[NR];
    int          rpos[NR];
    logic        model_mute = 1'b0;
    int          busy_left = 0;

    uart_tx_arbiter #(.N_REQ(NR), .ACK_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_busy   (tx_busy),
        .tx_enable (tx_enable),
        .tx_data   (tx_data),
        .grant     (grant),
        .tx_drop   (tx_drop)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy from the cycle after tx_enable for BUSY_LEN cycles
    always @(posedge clk) begin
        if (tx_enable && !model_mute) busy_left <= BUSY_LEN;
        else if (busy_left > 0)       busy_left <= busy_left - 1;
    end
    assign tx_busy = (busy_left != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per transfer
    always @(posedge clk) begin
        logic [10:0]   e;
        logic [NR-1:0] oh;
        #1;
        if (tx_enable) begin
            chk("busy_at_enable", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got transfer data %0h req_ready %b, required none", tx_data, req_ready);
            end else begin
                e  = exp_q.pop_front();
                oh = 4'b0001 << e[10:8];
                chk("sb_data", {24'd0, tx_data}, {24'd0, e[7:0]});
                chk("sb_req_ready", {28'd0, req_ready}, {28'd0, oh});
                chk("sb_grant", {28'd0, grant}, {28'd0, oh});
            end
        end
    end

    // One cycle: advance requesters that were just accepted, then present their next byte
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && rpos[i] < rcnt[i]) rpos[i]++;
            if (rpos[i] < rcnt[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rbuf[i][rpos[i]][7:0];
                req_last[i]        = rbuf[i][rpos[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [7:0] d, input logic last);
        rbuf[i][rcnt[i]] = {last, d};
        rcnt[i]++;
    endtask

    task automatic expect_byte(input int i, input logic [7:0] d);
        logic [2:0] idx;
        idx = 3'(i);
        exp_q.push_back({idx, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (BUSY_LEN + 4) tick();
    endtask

    task automatic wait_enable(input string name);
        int n = 0;
        while (!tx_enable && n < 40) begin
            tick();
            n++;
        end
        chk(name, {31'd0, tx_enable}, 32'd1);
    endtask

    int   n;
    int   ncyc;
    int   fall;
    int   nen;
    logic bprev;
    logic early;

    initial begin
        for (int i = 0; i < NR; i++) begin
            rcnt[i] = 0;
            rpos[i] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_tx_drop", {31'd0, tx_drop}, 32'd0);
        reset = 1'b0;
        tick();

        // Single request: enable one cycle after the request is seen
        expect_byte(0, 8'h41);
        load(0, 8'h41, 1'b1);
        tick();
        tick();
        chk("t1_enable", {31'd0, tx_enable}, 32'd1);
        chk("t1_data", {24'd0, tx_data}, 32'h41);
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        n = 0;
        while (!tx_busy && n < 20) begin tick(); n++; end
        while (tx_busy && n < 60) begin tick(); n++; end
        chk("t1_grant_wait_done", {28'd0, grant}, 32'h1);
        tick();
        chk("t1_grant_idle", {28'd0, grant}, 32'h0);
        drain("t1_drain");

        // All four continuously: 0,1,2,3,0
        do_reset();
        expect_byte(0, 8'h10);
        expect_byte(1, 8'h11);
        expect_byte(2, 8'h12);
        expect_byte(3, 8'h13);
        expect_byte(0, 8'h14);
        load(0, 8'h10, 1'b1);
        load(0, 8'h14, 1'b1);
        load(1, 8'h11, 1'b1);
        load(2, 8'h12, 1'b1);
        load(3, 8'h13, 1'b1);
        drain("t2_drain");

        // Packet: req0 sends 3 bytes (last=0,0,1) while req1 is valid
        do_reset();
`ifdef UART_TX_ARBITER_LOCK_EN
        expect_byte(0, 8'hA0);
        expect_byte(0, 8'hA1);
        expect_byte(0, 8'hA2);
        expect_byte(1, 8'hB0);
`else
        expect_byte(0, 8'hA0);
        expect_byte(1, 8'hB0);
        expect_byte(0, 8'hA1);
        expect_byte(0, 8'hA2);
`endif
        load(0, 8'hA0, 1'b0);
        load(0, 8'hA1, 1'b0);
        load(0, 8'hA2, 1'b1);
        load(1, 8'hB0, 1'b1);
        ncyc  = 0;
        fall  = -100;
        nen   = 0;
        bprev = 1'b0;
        while (nen < 4 && ncyc < 800) begin
            tick();
            ncyc++;
            if (bprev && !tx_busy) fall = ncyc;
            bprev = tx_busy;
            if (tx_enable) begin
                nen++;
                if (nen == 2) chk("t3_gap2", ncyc - fall, GAP);
                if (nen == 3) chk("t3_gap3", ncyc - fall, GAP);
            end
        end
        chk("t3_enables", nen, 4);
        drain("t3_drain");

        // Ack timeout: uart_tx never goes busy
        do_reset();
        model_mute = 1'b1;
        expect_byte(0, 8'h5A);
        load(0, 8'h5A, 1'b0);
        wait_enable("t4_enable");
        early = 1'b0;
        repeat (7) begin
            tick();
            if (tx_drop) early = 1'b1;
        end
        chk("t4_drop_early", {31'd0, early}, 32'd0);
        tick();
        chk("t4_drop_at_8", {31'd0, tx_drop}, 32'd1);
        tick();
        chk("t4_drop_pulse", {31'd0, tx_drop}, 32'd0);
        chk("t4_grant_idle", {28'd0, grant}, 32'h0);
        model_mute = 1'b0;
        // A stuck lock would starve requester 1
        expect_byte(1, 8'h66);
        load(1, 8'h66, 1'b1);
        drain("t4_drain");

        // Reset during WAIT_DONE while uart_tx is mid-frame
        expect_byte(1, 8'h31);
        load(1, 8'h31, 1'b1);
        wait_enable("t5_enable");
        repeat (4) tick();
        load(2, 8'h72, 1'b1);
        tick();
        reset = 1'b1;
        load(0, 8'h03, 1'b1);
        tick();
        chk("t5_rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        chk("t5_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("t5_rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("t5_rst_grant", {28'd0, grant}, 32'd0);
        chk("t5_rst_tx_drop", {31'd0, tx_drop}, 32'd0);
        reset = 1'b0;
        expect_byte(0, 8'h03);
        expect_byte(2, 8'h72);
        drain("t5_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx_arbiter
